// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register and next-address selection.
// Arbitrates redirects, holds on stall and defers redirects seen during a stall.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   stall                    freeze the IF stage (PC holds)
//   br_taken, br_target      taken branch from ID and its target
//   jmp, jmp_index, pc_id    J/JAL in ID, instr[25:0] and PC+4 of that instr
//   jr, jr_target            JR/JALR in ID and the forwarded rs value
//   exc                      exception request from later stages
//   pc, pc_plus4             current fetch address and pc + 4
//   flush_if                 squash the instruction entering IF/ID
//   pending                  a deferred redirect is held
//   addr_err                 misaligned JR target trapped this cycle
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic [31:0] pc_id,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush_if,
  output logic        pending,
  output logic        addr_err
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_tgt, tgt_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] sel_tgt;
  logic        redir;
  logic        jr_bad;
  logic        unused_ok;

  assign unused_ok = ^pc_id[27:0];
  assign pc_plus4  = pc + 32'd4;
  assign pending   = (state == HOLD);
  assign redir     = exc | jr | jmp | br_taken;
  assign jr_bad    = jr & (|jr_target[1:0]);

  always_comb begin
    sel_tgt = pc_plus4;
    priority case (1'b1)
      exc:      sel_tgt = EXC_VECTOR;
      jr:       sel_tgt = jr_bad ? EXC_VECTOR
                                 : jr_target;
      jmp:      sel_tgt = {pc_id[31:28],
                           jmp_index, 2'b00};
      br_taken: sel_tgt = br_target;
      default:  sel_tgt = pc_plus4;
    endcase
  end

  always_comb begin
    pc_nxt    = pc;
    state_nxt = state;
    tgt_nxt   = pend_tgt;
    flush_if  = 1'b0;
    addr_err  = 1'b0;
    if (rst) begin
      pc_nxt    = RESET_PC;
      state_nxt = RUN;
      tgt_nxt   = 32'd0;
    end else if (exc) begin
      // exc wins over stall and any held target
      pc_nxt    = EXC_VECTOR;
      state_nxt = RUN;
      flush_if  = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          // pulses once: a stalled jr moves to HOLD
          addr_err = jr_bad;
          if (redir) begin
            if (stall) begin
              tgt_nxt   = sel_tgt;
              state_nxt = HOLD;
            end else begin
              pc_nxt   = sel_tgt;
              flush_if = 1'b1;
            end
          end else if (!stall) begin
            pc_nxt = pc_plus4;
          end
        end
        HOLD: begin
          // ID is re-presenting the same redirect;
          // live jr/jmp/br are ignored here
          if (!stall) begin
            pc_nxt    = pend_tgt;
            flush_if  = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state    <= state_nxt;
    pc       <= pc_nxt;
    pend_tgt <= tgt_nxt;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboard bench for pc_sequencer.
// Driver pushes model expectations; monitor pops and compares.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_V  = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, jmp, jr, exc;
  logic [31:0] br_target, pc_id, jr_target;
  logic [25:0] jmp_index;
  logic [31:0] pc, pc_plus4;
  logic        flush_if, pending, addr_err;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_index(jmp_index),
    .pc_id(pc_id), .jr(jr),
    .jr_target(jr_target), .exc(exc),
    .pc(pc), .pc_plus4(pc_plus4),
    .flush_if(flush_if), .pending(pending),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        err;
    logic        p4_ok;
    logic [31:0] p4;
    logic [31:0] npc;
    logic        npend;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_known = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic s,
                       input logic b, input logic [31:0] bt,
                       input logic j, input logic [25:0] ji,
                       input logic [31:0] pid,
                       input logic jj, input logic [31:0] jt,
                       input logic e);
    exp_t x;
    logic [31:0] t;
    logic        have;
    @(negedge clk);
    rst = r; stall = s; br_taken = b; br_target = bt;
    jmp = j; jmp_index = ji; pc_id = pid;
    jr = jj; jr_target = jt; exc = e;
    x.flush = 1'b0; x.err = 1'b0;
    x.p4_ok = m_known; x.p4 = m_pc + 32'd4;
    x.npc = m_pc; x.npend = m_pend;
    if (r) begin
      x.npc = RST_PC; x.npend = 1'b0; m_tgt = 32'd0;
    end else if (e) begin
      x.npc = EXC_V; x.npend = 1'b0; x.flush = 1'b1;
    end else if (m_pend) begin
      if (!s) begin
        x.npc = m_tgt; x.npend = 1'b0; x.flush = 1'b1;
      end
    end else begin
      have = 1'b1;
      if (jj) begin
        t = (jt[1:0] == 2'b00) ? jt : EXC_V;
        x.err = (jt[1:0] != 2'b00);
      end else if (j) t = {pid[31:28], ji, 2'b00};
      else if (b) t = bt;
      else begin have = 1'b0; t = m_pc + 32'd4; end
      if (have && s) begin
        m_tgt = t; x.npend = 1'b1;
      end else if (have) begin
        x.npc = t; x.flush = 1'b1;
      end else if (!s) x.npc = t;
    end
    m_pc = x.npc; m_pend = x.npend; m_known = 1'b1;
    q.push_back(x);
  endtask

  task automatic idle(input logic s);
    drive(1'b0, s, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0,
          1'b0, 32'd0, 1'b0);
  endtask

  task automatic br(input logic s, input logic [31:0] bt);
    drive(1'b0, s, 1'b1, bt, 1'b0, 26'd0, 32'd0,
          1'b0, 32'd0, 1'b0);
  endtask

  // monitor: comb outputs just before the edge,
  // registered outputs just after it
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("flush_if", {31'd0, flush_if}, {31'd0, x.flush});
        chk("addr_err", {31'd0, addr_err}, {31'd0, x.err});
        if (x.p4_ok) chk("pc_plus4", pc_plus4, x.p4);
        @(posedge clk);
        #1;
        chk("pc", pc, x.npc);
        chk("pending", {31'd0, pending}, {31'd0, x.npend});
      end
    end
  end

  initial begin
    m_pc = 32'd0; m_pend = 1'b0; m_tgt = 32'd0;
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0;
    br_target = 32'd0; jmp = 1'b0; jmp_index = 26'd0;
    pc_id = 32'd0; jr = 1'b0; jr_target = 32'd0;
    exc = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0,
          1'b0, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'h5, 1'b1, 26'h1, 32'd0,
          1'b1, 32'h1, 1'b1);
    repeat (3) idle(1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 26'h0000100,
          32'h1000_0040, 1'b0, 32'd0, 1'b0);
    idle(1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h3100, 1'b0, 26'd0, 32'd0,
          1'b1, 32'h5000, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0,
          1'b1, 32'h5002, 1'b0);
    idle(1'b0);
    repeat (3) br(1'b1, 32'h3200);
    idle(1'b0);
    br(1'b1, 32'h3300);
    drive(1'b0, 1'b1, 1'b1, 32'h3300, 1'b0, 26'd0, 32'd0,
          1'b0, 32'd0, 1'b1);
    idle(1'b0);
    br(1'b0, 32'hFFFF_FFFC);
    idle(1'b0);
    br(1'b1, 32'h3400);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0, 32'd0,
          1'b0, 32'd0, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 59) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), $urandom,
            ($urandom_range(0, 5) == 0),
            26'($urandom), $urandom,
            ($urandom_range(0, 6) == 0),
            {$urandom_range(0, 3) == 0 ?
               30'($urandom) : 30'($urandom),
             ($urandom_range(0, 3) == 0) ?
               2'($urandom_range(1, 3)) : 2'b00},
            ($urandom_range(0, 15) == 0));
    end
    for (int k = 0; k < 10 && q.size() != 0; k++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
